// File: rtl/ip_pkg.sv
// ip_pkg: shared IPv4 definitions for the RX decoder and TX encoder.
// Holds reject reason codes, header byte offsets, the RX parser state type
// and the ones'-complement add used by the checksum accumulator.
package ip_pkg;
   localparam logic [2:0] ERR_VERSION = 3'd1;
   localparam logic [2:0] ERR_IHL     = 3'd2;
   localparam logic [2:0] ERR_LEN     = 3'd3;
   localparam logic [2:0] ERR_CSUM    = 3'd4;
   localparam logic [2:0] ERR_FRAG    = 3'd5;
   localparam logic [2:0] ERR_DST     = 3'd6;
   localparam logic [2:0] ERR_TRUNC   = 3'd7;
   localparam logic [5:0] OFF_TLEN_HI  = 6'd2;
   localparam logic [5:0] OFF_TLEN_LO  = 6'd3;
   localparam logic [5:0] OFF_FLAGS_HI = 6'd6;
   localparam logic [5:0] OFF_FLAGS_LO = 6'd7;
   localparam logic [5:0] OFF_PROTO    = 6'd9;
   localparam logic [5:0] OFF_CSUM     = 6'd10;
   localparam logic [5:0] OFF_SRC      = 6'd12;
   localparam logic [5:0] OFF_DST      = 6'd16;
   localparam logic [3:0] MIN_IHL      = 4'd5;
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} IP_RX_STATE;
   // ones'-complement add with the end-around carry folded back in
   function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction
endpackage

// File: rtl/ip_csum16.sv
// ip_csum16: running 16-bit ones'-complement sum over a big-endian byte stream.
// Ports: clk, rst (sync, active-high); clr zeroes the sum; en qualifies din;
// phase=0 holds din as the high byte, phase=1 adds {held, din}; sum is the
// registered running total.
module ip_csum16
   import ip_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   input  logic        phase,
   output logic [15:0] sum
);
   logic [7:0] hi;
   always_ff @(posedge clk) begin
      if (rst) begin
         hi  <= 8'd0;
         sum <= 16'd0;
      end else begin
         if (en && !phase) hi <= din;
         if (clr) sum <= 16'd0;
         else if (en && phase) sum <= csum_add(sum, {hi, din});
      end
   end
endmodule

// File: rtl/ipv4_rx_decode.sv
// ipv4_rx_decode: IPv4 header parser and payload forwarder for the RX path.
// Ports: clk, rst (sync, active-high); valid/din byte stream starting at the
// version/IHL byte; src_ip, dst_ip, protocol, total_len latched header fields;
// hdr_ok / err one-cycle verdict pulses with err_code; dout, dout_valid,
// dout_last carry the payload with Ethernet padding removed.
module ipv4_rx_decode #(
   parameter logic [31:0] IP_ADDR      = 32'h69696969,
   parameter bit          ACCEPT_BCAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [7:0]  din,
   output logic [31:0] src_ip,
   output logic [31:0] dst_ip,
   output logic [7:0]  protocol,
   output logic [15:0] total_len,
   output logic        hdr_ok,
   output logic [7:0]  dout,
   output logic        dout_valid,
   output logic        dout_last,
   output logic        err,
   output logic [2:0]  err_code
);
   import ip_pkg::*;
   IP_RX_STATE  state;
   logic [5:0]  cnt;
   logic [15:0] pay_cnt;
   logic [15:0] frag;
   logic [3:0]  ver;
   logic [3:0]  ihl;
   logic [7:0]  prev;
   logic [15:0] csum_sum;
   logic [5:0]  hdr_last;
   logic [15:0] hdr_len;
   logic [15:0] pay_len;
   logic [31:0] dst_n;
   logic        csum_ok;
   logic        dst_ok;
   logic [2:0]  code;
   ip_csum16 u_csum (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == IDLE),
      .en    (valid && (state == IDLE || state == HDR)),
      .din   (din),
      .phase (state == HDR && cnt[0]),
      .sum   (csum_sum)
   );
   // The verdict is registered on the last header byte, so the final checksum
   // pair and the last destination byte are folded in combinationally here.
   always_comb begin
      hdr_last = {ihl, 2'b00} - 6'd1;
      hdr_len  = {10'd0, ihl, 2'b00};
      pay_len  = total_len - hdr_len;
      dst_n    = cnt[5:2] == OFF_DST[5:2] ? {dst_ip[23:0], din} : dst_ip;
      csum_ok  = csum_add(csum_sum, {prev, din}) == 16'hFFFF;
      dst_ok   = dst_n == IP_ADDR || (ACCEPT_BCAST && dst_n == 32'hFFFF_FFFF);
      code     = ver != 4'd4 ? ERR_VERSION :
                 total_len < hdr_len ? ERR_LEN :
                 !csum_ok ? ERR_CSUM :
                 (frag[13] || frag[12:0] != 13'd0) ? ERR_FRAG :
                 !dst_ok ? ERR_DST : 3'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 6'd0;
         pay_cnt    <= 16'd0;
         frag       <= 16'd0;
         ver        <= 4'd0;
         ihl        <= 4'd0;
         prev       <= 8'd0;
         src_ip     <= 32'd0;
         dst_ip     <= 32'd0;
         protocol   <= 8'd0;
         total_len  <= 16'd0;
         hdr_ok     <= 1'b0;
         err        <= 1'b0;
         err_code   <= 3'd0;
         dout       <= 8'd0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
      end else begin
         hdr_ok     <= 1'b0;
         err        <= 1'b0;
         err_code   <= 3'd0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         prev       <= din;
         case (state)
            IDLE: if (valid) begin
               ver <= din[7:4];
               ihl <= din[3:0];
               cnt <= 6'd1;
               // a header shorter than 20 bytes cannot be walked, reject at once
               if (din[3:0] < MIN_IHL) begin
                  err      <= 1'b1;
                  err_code <= din[7:4] != 4'd4 ? ERR_VERSION : ERR_IHL;
                  state    <= DRAIN;
               end else state <= HDR;
            end
            HDR: if (!valid) begin
               err      <= 1'b1;
               err_code <= ERR_TRUNC;
               state    <= IDLE;
            end else begin
               cnt <= cnt + 6'd1;
               if (cnt == OFF_TLEN_HI) total_len[15:8] <= din;
               if (cnt == OFF_TLEN_LO) total_len[7:0] <= din;
               if (cnt == OFF_FLAGS_HI) frag[15:8] <= din;
               if (cnt == OFF_FLAGS_LO) frag[7:0] <= din;
               if (cnt == OFF_PROTO) protocol <= din;
               if (cnt[5:2] == OFF_SRC[5:2]) src_ip <= {src_ip[23:0], din};
               dst_ip <= dst_n;
               if (cnt == hdr_last) begin
                  if (code != 3'd0) begin
                     err      <= 1'b1;
                     err_code <= code;
                     state    <= DRAIN;
                  end else begin
                     hdr_ok  <= 1'b1;
                     pay_cnt <= pay_len;
                     state   <= pay_len == 16'd0 ? DRAIN : PAYLOAD;
                  end
               end
            end
            PAYLOAD: if (!valid) begin
               err      <= 1'b1;
               err_code <= ERR_TRUNC;
               state    <= IDLE;
            end else begin
               dout       <= din;
               dout_valid <= 1'b1;
               pay_cnt    <= pay_cnt - 16'd1;
               // anything after the counted payload is Ethernet padding
               if (pay_cnt == 16'd1) begin
                  dout_last <= 1'b1;
                  state     <= DRAIN;
               end
            end
            DRAIN: if (!valid) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ipv4_rx_decode.sv
// tb_ipv4_rx_decode: table-driven and randomized checks of ipv4_rx_decode.
module tb_ipv4_rx_decode;
   localparam logic [31:0] MY_IP = 32'hC0A800C7;
   logic        clk, rst, valid;
   logic [7:0]  din;
   logic [31:0] src_ip, dst_ip;
   logic [7:0]  protocol;
   logic [15:0] total_len;
   logic        hdr_ok, dout_valid, dout_last, err;
   logic [7:0]  dout;
   logic [2:0]  err_code;

   ipv4_rx_decode #(.IP_ADDR(MY_IP), .ACCEPT_BCAST(1'b1)) dut (
      .clk(clk), .rst(rst), .valid(valid), .din(din),
      .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol), .total_len(total_len),
      .hdr_ok(hdr_ok), .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
      .err(err), .err_code(err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      int          ver, ihl, plen;
      logic [31:0] dst;
      logic [7:0]  b6, b7;
      bit          bad;
      int          pad, trunc;
      int          e_ok, e_code, e_n;
   } vec_t;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [7:0] frm[$];
   int obs_ok[$], exp_ok[$], obs_err[$], exp_err[$];
   logic [8:0] obs_pay[$], exp_pay[$];
   vec_t tbl[15];

   always @(posedge clk) begin
      cyc++;
      #1;
      if (hdr_ok) obs_ok.push_back(cyc);
      if (err) obs_err.push_back(cyc * 8 + int'(err_code));
      if (dout_valid) obs_pay.push_back({dout_last, dout});
      if (hdr_ok && err) begin
         checks++;
         errors++;
         $display("FAIL overlap hdr_ok=1 err=1 at cycle %0d, required not both", cyc);
      end
   end

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic build(input int ver, input int ihl, input int plen, input logic [31:0] dst,
                        input logic [7:0] b6, input logic [7:0] b7, input bit bad,
                        input int pad, input int trunc);
      int hl, tl, s, cut;
      logic [15:0] cs;
      hl = ihl < 5 ? 20 : ihl * 4;
      tl = hl + plen;
      frm.delete();
      frm.push_back({ver[3:0], ihl[3:0]});
      frm.push_back(8'h00);
      frm.push_back(tl[15:8]);
      frm.push_back(tl[7:0]);
      frm.push_back(8'h00);
      frm.push_back(8'h00);
      frm.push_back(b6);
      frm.push_back(b7);
      frm.push_back(8'h40);
      frm.push_back(8'h11);
      frm.push_back(8'h00);
      frm.push_back(8'h00);
      frm.push_back(8'hC0);
      frm.push_back(8'hA8);
      frm.push_back(8'h00);
      frm.push_back(8'h01);
      frm.push_back(dst[31:24]);
      frm.push_back(dst[23:16]);
      frm.push_back(dst[15:8]);
      frm.push_back(dst[7:0]);
      for (int i = 20; i < hl; i++) frm.push_back(8'h01);
      s = 0;
      for (int i = 0; i < hl; i += 2) s += int'({frm[i], frm[i + 1]});
      while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
      cs = ~s[15:0];
      if (bad) cs = cs + 16'd1;
      frm[10] = cs[15:8];
      frm[11] = cs[7:0];
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
      for (int i = 0; i < pad; i++) frm.push_back(8'($urandom));
      cut = trunc == -2 ? int'($urandom_range(1, frm.size() - 1)) : trunc;
      if (cut > 0) while (frm.size() > cut) void'(frm.pop_back());
   endtask

   // Reference: outcome of a received byte sequence derived from the IPv4 rules.
   task automatic model(input int start, output bit pass);
      int n, v, ih, hl, tl, s, code, plen;
      logic [31:0] d;
      pass = 1'b0;
      n  = frm.size();
      v  = int'(frm[0][7:4]);
      ih = int'(frm[0][3:0]);
      if (ih < 5) begin
         exp_err.push_back((start + 1) * 8 + (v != 4 ? 1 : 2));
         return;
      end
      hl = ih * 4;
      if (n < hl) begin
         exp_err.push_back((start + n + 1) * 8 + 7);
         return;
      end
      tl = int'(frm[2]) * 256 + int'(frm[3]);
      s = 0;
      for (int i = 0; i < hl; i += 2) s += int'(frm[i]) * 256 + int'(frm[i + 1]);
      while (s > 'hFFFF) s = (s & 'hFFFF) + (s >>> 16);
      d = {frm[16], frm[17], frm[18], frm[19]};
      code = v != 4 ? 1 : tl < hl ? 3 : s != 'hFFFF ? 4 :
             (frm[6][5] || {frm[6][4:0], frm[7]} != 13'd0) ? 5 :
             (d != MY_IP && d != 32'hFFFF_FFFF) ? 6 : 0;
      if (code != 0) begin
         exp_err.push_back((start + hl) * 8 + code);
         return;
      end
      pass = 1'b1;
      exp_ok.push_back(start + hl);
      plen = tl - hl;
      for (int i = 0; i < plen && hl + i < n; i++) exp_pay.push_back({i == plen - 1, frm[hl + i]});
      if (n - hl < plen) exp_err.push_back((start + n + 1) * 8 + 7);
   endtask

   task automatic drive_frame(output int start);
      start = 0;
      foreach (frm[i]) begin
         @(negedge clk);
         if (i == 0) start = cyc;
         valid = 1'b1;
         din = frm[i];
      end
      @(negedge clk);
      valid = 1'b0;
      din = 8'h00;
   endtask

   task automatic run(input string tag);
      int st;
      bit p;
      drive_frame(st);
      model(st, p);
      if (p) begin
         chk({tag, " src_ip"}, src_ip, {frm[12], frm[13], frm[14], frm[15]});
         chk({tag, " dst_ip"}, dst_ip, {frm[16], frm[17], frm[18], frm[19]});
         chk({tag, " protocol"}, protocol, frm[9]);
         chk({tag, " total_len"}, total_len, {frm[2], frm[3]});
      end
   endtask

   task automatic flush(input string tag);
      repeat (2) @(negedge clk);
      chk({tag, " hdr_ok count"}, obs_ok.size(), exp_ok.size());
      for (int i = 0; i < obs_ok.size() && i < exp_ok.size(); i++)
         chk({tag, " hdr_ok cycle"}, obs_ok[i], exp_ok[i]);
      chk({tag, " err count"}, obs_err.size(), exp_err.size());
      for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
         chk({tag, " err cycle*8+code"}, obs_err[i], exp_err[i]);
      chk({tag, " payload count"}, obs_pay.size(), exp_pay.size());
      for (int i = 0; i < obs_pay.size() && i < exp_pay.size(); i++)
         chk({tag, " payload {last,byte}"}, obs_pay[i], exp_pay[i]);
      obs_ok.delete(); exp_ok.delete();
      obs_err.delete(); exp_err.delete();
      obs_pay.delete(); exp_pay.delete();
   endtask

   task automatic run_vec(input vec_t v);
      build(v.ver, v.ihl, v.plen, v.dst, v.b6, v.b7, v.bad, v.pad, v.trunc);
      run(v.nm);
      repeat (2) @(negedge clk);
      chk({v.nm, " tbl hdr_ok"}, obs_ok.size(), v.e_ok);
      chk({v.nm, " tbl err_code"}, obs_err.size() > 0 ? obs_err[0] % 8 : 0, v.e_code);
      chk({v.nm, " tbl payload"}, obs_pay.size(), v.e_n);
      if (obs_pay.size() > 0) chk({v.nm, " tbl last"}, obs_pay[$][8], v.e_code == 0);
      flush(v.nm);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      bit p;
      tbl = '{
         '{"basic",    4, 5,  95, MY_IP,         8'h40, 8'h00, 1'b0, 6, -1, 1, 0, 95},
         '{"badcs",    4, 5,  95, MY_IP,         8'h40, 8'h00, 1'b1, 6, -1, 0, 4, 0},
         '{"opts",     4, 6,  30, MY_IP,         8'h40, 8'h00, 1'b0, 4, -1, 1, 0, 30},
         '{"dst_other",4, 5,  10, 32'hC0A80002,  8'h40, 8'h00, 1'b0, 0, -1, 0, 6, 0},
         '{"bcast",    4, 5,  10, 32'hFFFFFFFF,  8'h00, 8'h00, 1'b0, 2, -1, 1, 0, 10},
         '{"mf",       4, 5,  10, MY_IP,         8'h20, 8'h00, 1'b0, 0, -1, 0, 5, 0},
         '{"fragoff",  4, 5,  10, MY_IP,         8'h00, 8'h01, 1'b0, 0, -1, 0, 5, 0},
         '{"ver6",     6, 5,  10, MY_IP,         8'h40, 8'h00, 1'b0, 0, -1, 0, 1, 0},
         '{"ihl3",     4, 3,  10, MY_IP,         8'h40, 8'h00, 1'b0, 0, -1, 0, 2, 0},
         '{"tlshort",  4, 5,  -4, MY_IP,         8'h40, 8'h00, 1'b0, 0, -1, 0, 3, 0},
         '{"zeropay",  4, 5,   0, MY_IP,         8'h40, 8'h00, 1'b0, 6, -1, 1, 0, 0},
         '{"trunchdr", 4, 5,  95, MY_IP,         8'h40, 8'h00, 1'b0, 0, 13, 0, 7, 0},
         '{"truncpay", 4, 5,  20, MY_IP,         8'h40, 8'h00, 1'b0, 0, 30, 1, 7, 10},
         '{"ihl15",    4, 15,  5, MY_IP,         8'h40, 8'h00, 1'b0, 3, -1, 1, 0, 5},
         '{"csdst",    4, 5,  10, 32'hC0A80002,  8'h40, 8'h00, 1'b1, 0, -1, 0, 4, 0}
      };
      rst = 1'b1;
      valid = 1'b0;
      din = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset hdr_ok", hdr_ok, 0);
      chk("reset err", err, 0);
      chk("reset err_code", err_code, 0);
      chk("reset dout_valid", dout_valid, 0);
      chk("reset dout_last", dout_last, 0);
      chk("reset dout", dout, 0);
      chk("reset src_ip", src_ip, 0);
      chk("reset dst_ip", dst_ip, 0);
      chk("reset protocol", protocol, 0);
      chk("reset total_len", total_len, 0);
      rst = 1'b0;
      obs_ok.delete(); obs_err.delete(); obs_pay.delete();
      build(4, 5, 95, MY_IP, 8'h40, 8'h00, 1'b0, 6, -1);
      chk("hdr bytes 10-11", {frm[10], frm[11]}, 16'hB861);
      foreach (tbl[i]) run_vec(tbl[i]);
      // truncated header followed by a frame one idle cycle later
      build(4, 5, 40, MY_IP, 8'h40, 8'h00, 1'b0, 0, 13);
      run("b2b_trunc");
      build(4, 5, 12, MY_IP, 8'h40, 8'h00, 1'b0, 3, -1);
      run("b2b_next");
      flush("b2b");
      // reset while forwarding payload byte 10
      build(4, 5, 40, MY_IP, 8'h40, 8'h00, 1'b0, 0, -1);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         valid = 1'b1;
         din = frm[i];
      end
      @(negedge clk);
      din = frm[30];
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("midrst dout_valid", dout_valid, 0);
      chk("midrst src_ip", src_ip, 0);
      chk("midrst dst_ip", dst_ip, 0);
      chk("midrst protocol", protocol, 0);
      chk("midrst total_len", total_len, 0);
      chk("midrst hdr_ok", hdr_ok, 0);
      chk("midrst err", err, 0);
      chk("midrst hdr_ok seen", obs_ok.size(), 1);
      chk("midrst payload seen", obs_pay.size(), 10);
      @(negedge clk);
      rst = 1'b0;
      valid = 1'b0;
      obs_ok.delete(); obs_err.delete(); obs_pay.delete();
      run_vec(tbl[0]);
      // randomized frames, mostly back-to-back
      for (int r = 0; r < 60; r++) begin
         int ver, ihl, plen, pad, trunc, dsel;
         logic [31:0] dst;
         logic [7:0] b6, b7;
         bit bad;
         ver  = $urandom_range(0, 15) == 0 ? 6 : 4;
         ihl  = $urandom_range(0, 15) == 0 ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 8));
         plen = $urandom_range(0, 15) == 0 ? -int'($urandom_range(1, 8)) : int'($urandom_range(0, 30));
         dsel = $urandom_range(0, 3);
         dst  = dsel == 0 ? $urandom : dsel == 1 ? 32'hFFFFFFFF : MY_IP;
         b6   = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 8'h20 : 8'h01) : 8'h40;
         b7   = $urandom_range(0, 15) == 0 ? 8'($urandom_range(1, 255)) : 8'h00;
         bad  = $urandom_range(0, 7) == 0;
         pad  = $urandom_range(0, 6);
         trunc = $urandom_range(0, 7) == 0 ? -2 : -1;
         build(ver, ihl, plen, dst, b6, b7, bad, pad, trunc);
         run("rand");
         if (r % 5 == 4) flush("rand");
      end
      flush("rand_end");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
